// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bus bundle between the UART command sequencer and its neighbours:
// the UART receiver, the register file, the ALU and the UART transmitter.
interface uart_rx_cmd_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0]   rx_p_data;
  logic                rx_d_valid;
  logic                rx_par_err;
  logic                rx_stp_err;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_valid;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_valid;
  logic                tx_ready;
  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic                alu_en;
  logic [3:0]          alu_fun;
  logic                clk_gate_en;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_valid;
  logic                frame_err;

  // Sequencer side
  modport master (
    input  rx_p_data, rx_d_valid, rx_par_err, rx_stp_err,
    input  rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
    output clk_gate_en, tx_data, tx_valid, frame_err
  );

  // Environment side (receiver, register file, ALU, transmitter)
  modport slave (
    output rx_p_data, rx_d_valid, rx_par_err, rx_stp_err,
    output rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
    input  clk_gate_en, tx_data, tx_valid, frame_err
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// UART command sequencer: parses received bytes into register-file and ALU
// commands and returns read/ALU results to the transmitter. Frames with a
// parity/stop error or an inter-byte timeout are dropped with frame_err.
module uart_rx_cmd_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic            clk,
  input logic            rst,
  uart_rx_cmd_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CntMax = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] OpWr   = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OpRd   = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OpAlu  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OpAluN = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait,
    StAluA, StAluB, StAluFun, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              alu_en_q, alu_en_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic              clk_gate_en_q, clk_gate_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] hi_q, hi_d;        // ALU result high byte awaiting TX_HI
  logic              is_alu_q, is_alu_d; // TX_LO carries an ALU result

  logic collecting, byte_ok, byte_bad, timeout;

  assign collecting = (state_q == StWrAddr) || (state_q == StWrData) ||
                      (state_q == StRdAddr) || (state_q == StAluA)   ||
                      (state_q == StAluB)   || (state_q == StAluFun);
  assign byte_ok  = bus.rx_d_valid & ~bus.rx_par_err & ~bus.rx_stp_err;
  assign byte_bad = bus.rx_d_valid & (bus.rx_par_err | bus.rx_stp_err);
  assign timeout  = collecting & ~bus.rx_d_valid & (cnt_q == CntMax);

  // Next-state, strobe and held-output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    frame_err_d  = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    hi_d         = hi_q;
    is_alu_d     = is_alu_q;

    // Inter-byte counter restarts on every byte and runs only while collecting
    if (collecting && !bus.rx_d_valid && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Error bytes in IDLE are silently ignored
        if (byte_ok) begin
          if (bus.rx_p_data == OpWr) begin
            state_d = StWrAddr;
          end else if (bus.rx_p_data == OpRd) begin
            state_d = StRdAddr;
          end else if (bus.rx_p_data == OpAlu) begin
            state_d = StAluA;
          end else if (bus.rx_p_data == OpAluN) begin
            state_d = StAluFun;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (byte_ok) begin
          rf_addr_d = bus.rx_p_data[ADDR_W-1:0];
          state_d   = StWrData;
        end
      end
      StWrData: begin
        if (byte_ok) begin
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StIdle;
        end
      end
      StRdAddr: begin
        if (byte_ok) begin
          rf_addr_d  = bus.rx_p_data[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (bus.rf_rd_valid) begin
          tx_data_d  = bus.rf_rd_data;
          tx_valid_d = 1'b1;
          is_alu_d   = 1'b0;
          state_d    = StTxLo;
        end
      end
      StAluA: begin
        if (byte_ok) begin
          rf_addr_d    = '0;
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StAluB;
        end
      end
      StAluB: begin
        if (byte_ok) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StAluFun;
        end
      end
      StAluFun: begin
        if (byte_ok) begin
          alu_fun_d = bus.rx_p_data[3:0];
          alu_en_d  = 1'b1;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        if (bus.alu_valid) begin
          tx_data_d  = bus.alu_out[DATA_W-1:0];
          hi_d       = bus.alu_out[2*DATA_W-1:DATA_W];
          tx_valid_d = 1'b1;
          is_alu_d   = 1'b1;
          state_d    = StTxLo;
        end
      end
      StTxLo: begin
        if (bus.tx_ready) begin
          if (is_alu_q) begin
            tx_data_d = hi_q;
            state_d   = StTxHi;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      StTxHi: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A bad byte or a timeout aborts the frame being collected
    if (collecting && (byte_bad || timeout)) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      rf_wr_en_d  = 1'b0;
      rf_rd_en_d  = 1'b0;
      alu_en_d    = 1'b0;
    end

    clk_gate_en_d = (state_d == StAluFun) || (state_d == StAluWait);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      hi_q          <= '0;
      is_alu_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      frame_err_q   <= frame_err_d;
      hi_q          <= hi_d;
      is_alu_q      <= is_alu_d;
    end
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule
